mpmc_app_cmd_gen: RTL and testbench
===================================

// Module: mpmc_app_cmd_gen
// PURPOSE
//   Parametrised MIG application-command issuer for the mpmc controller. Owns
//   its own FSM: takes one start request (read or write, N+1 strips), drives
//   app_en/app_cmd/app_addr with retry on !app_rdy, and drives the write-data
//   FIFO strobes with an independent retry on !app_wdf_rdy.
//   Sits between the port arbiter/data path and the MIG user interface.
// PARAMETERS
//   ADDR_W       32  app_addr / adr width
//   CNT_W        6   strip counter width; num_strips range 0..2^CNT_W-1
//   STRIP_BYTES  16  address increment per strip (power of two)
//   TIMEOUT      1023 stall limit in cycles (used only with MPMC_APP_TIMEOUT_EN)
// PORTS
//   clk           in   1       controller clock
//   rst           in   1       synchronous reset, active high
//   start         in   1       request; sampled only when busy==0
//   we            in   1       1=write, 0=read; sampled with start
//   adr           in   ADDR_W  first strip address; sampled with start
//   num_strips    in   CNT_W   last strip index (strips 0..num_strips)
//   busy          out  1       request in progress
//   done          out  1       one-cycle pulse, request finished
//   err           out  1       one-cycle pulse with done on timeout abort
//   strip_cnt     out  CNT_W   current strip index (write-data mux select)
//   app_rdy       in   1       MIG command accept
//   app_en        out  1       MIG command valid
//   app_cmd       out  3       CMD_WRITE=3'b000 / CMD_READ=3'b001
//   app_addr      out  ADDR_W  MIG command address
//   app_wdf_rdy   in   1       MIG write FIFO accept
//   app_wdf_wren  out  1       write data valid
//   app_wdf_end   out  1       last beat of strip (==app_wdf_wren, 1 beat/strip)
// BEHAVIOUR
//   - All outputs are flop-driven; reset (sync, rst=1) forces IDLE and every
//     output to 0, strip_cnt=0, app_addr=0. rst mid-request aborts, no done.
//   - States: IDLE -> ISSUE -> DONE -> IDLE.
//   - IDLE: start=1 latches we/adr/num_strips, clears strip_cnt, busy=1;
//     app_en=1 (and app_wdf_wren=1 if we) from the next cycle (1-cycle latency).
//   - Accept rules: command accepted on an edge with app_en&&app_rdy; data
//     accepted on an edge with app_wdf_wren&&app_wdf_rdy. A signal stays high
//     and app_addr/app_cmd stay stable until accepted, then drops to 0 until
//     the strip advances.
//   - Read strip advances on command accept. Write strip advances when both
//     command and data accepted (same cycle or either order).
//   - Advance: strip_cnt+1, app_addr+STRIP_BYTES (mod 2^ADDR_W, wraps), both
//     strobes re-armed next cycle, so back-to-back strips issue every cycle.
//   - Final strip (strip_cnt==num_strips) accepted -> DONE: done=1, busy=1,
//     strobes 0 for one cycle; then IDLE, busy=0; new start accepted from
//     that cycle.
//   - start while busy ignored. num_strips=0 -> exactly one strip.
// CONFIGURATION
//   MPMC_APP_TIMEOUT_EN defined: stall counter clears on any accept, counts
//   cycles in ISSUE otherwise; at TIMEOUT goes to DONE with done=1, err=1,
//   strobes dropped. Undefined: no counter, err tied 0, waits indefinitely.
// STRUCTURE
//   mpmc_pkg: state enum (IDLE, ISSUE, DONE), CMD_WRITE/CMD_READ constants,
//   TRUE/FALSE. No sub-module; optional timeout counter inline under macro.
// TESTING
//   1 read adr=0x1000 num_strips=3, app_rdy=1 -> app_en 4 consecutive cycles,
//     app_addr 0x1000/0x1010/0x1020/0x1030, app_cmd=001, done next cycle.
//   2 read num_strips=1, app_rdy=0 for 2 cycles on strip 1 -> app_en held,
//     app_addr stable 0x1010 for 3 cycles, done one cycle after accept.
//   3 write num_strips=1, app_rdy=1, app_wdf_rdy=0 for 3 cycles -> app_en
//     drops after cycle 1, wdf_wren held 4 cycles, strip_cnt stays 0 until then.
//   4 start pulsed while busy -> ignored; rst asserted mid-write -> next cycle
//     all outputs 0, busy=0, no done.
//   5 read adr=0xFFFF_FFF0 num_strips=1 -> second app_addr=0x0000_0000.
//   6 with MPMC_APP_TIMEOUT_EN, app_rdy=0 -> done=err=1 after TIMEOUT cycles,
//     app_en=0; without macro no done within 2*TIMEOUT cycles.

Source files
------------

// File: rtl/mpmc_pkg.sv
// Shared types and constants for the mpmc controller.
// Holds the command-issuer state encoding and the MIG command codes.
package mpmc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/mpmc_app_cmd_gen.sv
// MIG application-command issuer.
// Takes one read/write request of num_strips+1 strips and drives app_en /
// app_cmd / app_addr and the write-data FIFO strobes, each retried
// independently until the MIG accepts it.
// Optional build macro: MPMC_APP_TIMEOUT_EN adds a stall counter that aborts
// a request (done+err) after TIMEOUT cycles without any accept.
//
// Handshake: a strobe (app_en or app_wdf_wren) is valid while high; a
// transfer happens on a clock edge where the strobe and its ready are both
// high. Until then the strobe, app_addr and app_cmd are held stable; after
// it the strobe drops to 0 until the next strip is armed.
module mpmc_app_cmd_gen
    import mpmc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 6,
    parameter int STRIP_BYTES = 16,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [CNT_W-1:0]  num_strips,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  strip_cnt,
    input  logic              app_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_wdf_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output state_e            state_dbg
);

    state_e             state, state_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic               cmd_done_q, cmd_done_d;
    logic               data_done_q, data_done_d;
    logic               busy_d, done_d, err_d, en_d, wren_d;
    logic [CNT_W-1:0]   strip_d;
    logic [2:0]         cmd_d;
    logic [ADDR_W-1:0]  addr_d;

    logic cmd_acc, data_acc, any_acc, cmd_ok, data_ok, timeout_hit;

    assign cmd_acc  = app_en && app_rdy;
    assign data_acc = app_wdf_wren && app_wdf_rdy;
    assign any_acc  = cmd_acc || data_acc;
    // A strip is complete once its command, and for writes its data, have
    // both been taken, in either order or together.
    assign cmd_ok   = cmd_done_q || cmd_acc;
    assign data_ok  = !we_q || data_done_q || data_acc;
    assign state_dbg = state;

`ifdef MPMC_APP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] stall_cnt;

    // Stall counter: counts ISSUE cycles with no accept of either strobe.
    always_ff @(posedge clk) begin
        if (rst || state != ISSUE || any_acc) stall_cnt <= '0;
        else                                  stall_cnt <= stall_cnt + TO_W'(1);
    end

    assign timeout_hit = (state == ISSUE) && !any_acc &&
                         (stall_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = FALSE;
`endif

    // State and output registers; every output is flop-driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= FALSE;
            num_q        <= '0;
            cmd_done_q   <= FALSE;
            data_done_q  <= FALSE;
            busy         <= FALSE;
            done         <= FALSE;
            err          <= FALSE;
            strip_cnt    <= '0;
            app_en       <= FALSE;
            app_cmd      <= 3'b000;
            app_addr     <= '0;
            app_wdf_wren <= FALSE;
            app_wdf_end  <= FALSE;
        end else begin
            state        <= state_d;
            we_q         <= we_d;
            num_q        <= num_d;
            cmd_done_q   <= cmd_done_d;
            data_done_q  <= data_done_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            strip_cnt    <= strip_d;
            app_en       <= en_d;
            app_cmd      <= cmd_d;
            app_addr     <= addr_d;
            app_wdf_wren <= wren_d;
            app_wdf_end  <= wren_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        we_d        = we_q;
        num_d       = num_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        busy_d      = busy;
        done_d      = FALSE;
        err_d       = FALSE;
        strip_d     = strip_cnt;
        en_d        = app_en;
        cmd_d       = app_cmd;
        addr_d      = app_addr;
        wren_d      = app_wdf_wren;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    we_d        = we;
                    num_d       = num_strips;
                    cmd_done_d  = FALSE;
                    data_done_d = FALSE;
                    busy_d      = TRUE;
                    strip_d     = '0;
                    en_d        = TRUE;
                    wren_d      = we;
                    cmd_d       = we ? CMD_WRITE : CMD_READ;
                    addr_d      = adr;
                end
            end
            ISSUE: begin
                if (cmd_ok && data_ok) begin
                    cmd_done_d  = FALSE;
                    data_done_d = FALSE;
                    if (strip_cnt == num_q) begin
                        state_d = DONE;
                        done_d  = TRUE;
                        en_d    = FALSE;
                        wren_d  = FALSE;
                    end else begin
                        strip_d = strip_cnt + CNT_W'(1);
                        addr_d  = app_addr + ADDR_W'(STRIP_BYTES);
                        en_d    = TRUE;
                        wren_d  = we_q;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                    done_d  = TRUE;
                    err_d   = TRUE;
                    en_d    = FALSE;
                    wren_d  = FALSE;
                end else begin
                    cmd_done_d  = cmd_ok;
                    data_done_d = data_done_q || data_acc;
                    en_d        = app_en && !app_rdy;
                    wren_d      = app_wdf_wren && !app_wdf_rdy;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = FALSE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = FALSE;
                en_d    = FALSE;
                wren_d  = FALSE;
            end
        endcase
    end

endmodule

// File: tb/tb_mpmc_app_cmd_gen.sv
// Directed testbench for mpmc_app_cmd_gen with hand-computed expectations.
// Honours MPMC_APP_TIMEOUT_EN for the stall scenario.
module tb_mpmc_app_cmd_gen;
    import mpmc_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [CNT_W-1:0]  num_strips;
    logic              busy, done, err;
    logic [CNT_W-1:0]  strip_cnt;
    logic              app_rdy, app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_rdy, app_wdf_wren, app_wdf_end;
    state_e            state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    mpmc_app_cmd_gen #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIP_BYTES(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .we(we), .adr(adr),
        .num_strips(num_strips), .busy(busy), .done(done), .err(err),
        .strip_cnt(strip_cnt), .app_rdy(app_rdy), .app_en(app_en),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_rdy(app_wdf_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a request: start is seen by the DUT on the next edge.
    task automatic launch(input logic w, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        start = 1'b1; we = w; adr = a; num_strips = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; we = 1'b0; adr = '0; num_strips = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_en", app_en, 0);
        check("rst_addr", app_addr, 0);
        check("rst_strip", strip_cnt, 0);
        check("rst_wren", app_wdf_wren, 0);
        rst = 1'b0;
        tick();

        // 1: four-strip read with app_rdy held high
        app_rdy = 1'b1;
        launch(1'b0, 32'h1000, 6'd3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_en%0d", i), app_en, 1);
            check($sformatf("t1_addr%0d", i), app_addr, 32'h1000 + 32'(i * 16));
            check($sformatf("t1_strip%0d", i), strip_cnt, i);
            tick();
        end
        check("t1_cmd_rd", 32'(dut.app_cmd), 32'(CMD_READ));
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 1);
        check("t1_en_off", app_en, 0);
        tick();
        check("t1_done_off", done, 0);
        check("t1_idle", busy, 0);

        // 2: read with command stalled on strip 1
        launch(1'b0, 32'h1000, 6'd1);
        check("t2_cmd", app_cmd, 32'(CMD_READ));
        tick();
        app_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_hold_en%0d", i), app_en, 1);
            check($sformatf("t2_hold_addr%0d", i), app_addr, 32'h1010);
            check($sformatf("t2_nodone%0d", i), done, 0);
            if (i < 2) tick();
        end
        app_rdy = 1'b1;
        tick();
        check("t2_done", done, 1);
        tick();

        // 3: write with the data FIFO stalled
        app_wdf_rdy = 1'b0;
        launch(1'b1, 32'h2000, 6'd1);
        check("t3_cmd_wr", app_cmd, 32'(CMD_WRITE));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_en%0d", i), app_en, (i == 0) ? 1 : 0);
            check($sformatf("t3_wren%0d", i), app_wdf_wren, 1);
            check($sformatf("t3_end%0d", i), app_wdf_end, 1);
            check($sformatf("t3_strip%0d", i), strip_cnt, 0);
            if (i < 3) tick();
        end
        app_wdf_rdy = 1'b1;
        tick();
        check("t3_strip1", strip_cnt, 1);
        check("t3_en1", app_en, 1);
        check("t3_wren1", app_wdf_wren, 1);
        check("t3_addr1", app_addr, 32'h2010);
        tick();
        check("t3_done", done, 1);
        check("t3_wren_off", app_wdf_wren, 0);
        tick();

        // 4: start while busy is ignored; reset mid-write aborts silently
        launch(1'b1, 32'h3000, 6'd3);
        start = 1'b1; we = 1'b0; adr = 32'h9000; num_strips = 6'd0;
        tick();
        start = 1'b0;
        check("t4_ignore_addr", app_addr, 32'h3010);
        check("t4_ignore_strip", strip_cnt, 1);
        check("t4_ignore_cmd", app_cmd, 32'(CMD_WRITE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_en", app_en, 0);
        check("t4_rst_wren", app_wdf_wren, 0);
        check("t4_rst_addr", app_addr, 0);
        check("t4_rst_strip", strip_cnt, 0);
        check("t4_rst_done", done, 0);
        tick();
        check("t4_after_done", done, 0);
        check("t4_after_busy", busy, 0);

        // 5: address wraps past the top of the space
        launch(1'b0, 32'hFFFF_FFF0, 6'd1);
        check("t5_addr0", app_addr, 32'hFFFF_FFF0);
        tick();
        check("t5_addr1", app_addr, 32'h0000_0000);
        tick();
        check("t5_done", done, 1);
        tick();

        // num_strips=0 issues exactly one strip
        launch(1'b0, 32'h4000, 6'd0);
        check("t5b_en", app_en, 1);
        tick();
        check("t5b_done", done, 1);
        check("t5b_en_off", app_en, 0);
        tick();

        // 6: command never accepted
        app_rdy = 1'b0;
        launch(1'b0, 32'h5000, 6'd0);
        seen = 0;
`ifdef MPMC_APP_TIMEOUT_EN
        for (int i = 1; i <= 2 * TIMEOUT; i++) begin
            tick();
            if (done) begin seen = i; break; end
        end
        check("t6_to_cycles", seen, TIMEOUT);
        check("t6_err", err, 1);
        check("t6_en_off", app_en, 0);
        tick();
        check("t6_err_off", err, 0);
        check("t6_idle", busy, 0);
`else
        for (int i = 1; i <= 2 * TIMEOUT; i++) begin
            tick();
            if (done) begin seen = i; break; end
        end
        check("t6_no_done", seen, 0);
        check("t6_err0", err, 0);
        check("t6_still_en", app_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
